xrv_id: RTL and testbench

Instruction decode stage of the xriscv core, between the fetch unit and the execute stage. Accepts fetched 32-bit RV32I instruction words through a small skid FIFO and decodes them into registered one-hot opcode flags, immediates and register indices. Issues them to execute as single-cycle `ex_valid` pulses. Honours execute's back-pressure signals (`ncycle_alu_wait`, `ls_done`) and flushes on `ex_jmp`.

---
 rtl/xrv_id.sv | 189 ++++++++++++++++++
 tb/tb_xrv_id.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrv_id.sv
// xriscv decode stage: skid FIFO of fetched words feeding a registered
// RV32I decoder that issues single-cycle pulses to execute.
module xrv_id #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   output logic        if_ready,
   input  logic        ex_jmp,
   input  logic        ncycle_alu_wait,
   input  logic        ls_done,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic        op_lui,
   output logic        op_auipc,
   output logic        op_jal,
   output logic        op_jalr,
   output logic        op_branch,
   output logic        op_load,
   output logic        op_store,
   output logic        op_imm,
   output logic        op_reg,
   output logic        op_is_compressed,
   output logic [31:0] imm_signed,
   output logic [31:0] imm_unsigned,
   output logic [4:0]  src1,
   output logic [4:0]  src2,
   output logic [4:0]  dest,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        illegal_instr
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pc_q  [DEPTH];
   logic [31:0]   ins_q [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          ls_wait;
   logic          alu_hold;
   logic          push;
   logic          issue;
   logic [31:0]   instr;
   logic          d_lui, d_auipc, d_jal, d_jalr, d_branch;
   logic          d_load, d_store, d_imm, d_reg, known;
   logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign if_ready = ~rst & (count < CW'(DEPTH));
   assign push     = if_valid & if_ready & ~ex_jmp;
   assign issue    = (count != '0) & ~ls_wait & ~alu_hold & ~ex_jmp;
   assign instr    = ins_q[rd_ptr];
   assign op_is_compressed = 1'b0;

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

   always_comb begin
      d_lui    = 1'b0;
      d_auipc  = 1'b0;
      d_jal    = 1'b0;
      d_jalr   = 1'b0;
      d_branch = 1'b0;
      d_load   = 1'b0;
      d_store  = 1'b0;
      d_imm    = 1'b0;
      d_reg    = 1'b0;
      known    = 1'b1;
      unique case (instr[6:0])
         7'b0110111: d_lui    = 1'b1;
         7'b0010111: d_auipc  = 1'b1;
         7'b1101111: d_jal    = 1'b1;
         7'b1100111: d_jalr   = 1'b1;
         7'b1100011: d_branch = 1'b1;
         7'b0000011: d_load   = 1'b1;
         7'b0100011: d_store  = 1'b1;
         7'b0010011: d_imm    = 1'b1;
         7'b0110011: d_reg    = 1'b1;
         7'b0001111, 7'b1110011: ;
         default:    known    = 1'b0;
      endcase
   end

   always_comb begin
      imm_sel = '0;
      unique case (1'b1)
         d_jalr | d_load | d_imm: imm_sel = imm_i;
         d_store:                 imm_sel = imm_s;
         d_branch:                imm_sel = imm_b;
         d_lui | d_auipc:         imm_sel = imm_u;
         d_jal:                   imm_sel = imm_j;
         default: ;
      endcase
   end

   // Payload storage needs no reset; validity lives in count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr]  <= if_pc;
         ins_q[wr_ptr] <= if_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         ls_wait  <= 1'b0;
         alu_hold <= 1'b0;
      end else begin
         alu_hold <= ncycle_alu_wait;
         if (issue & (d_load | d_store))
            ls_wait <= 1'b1;
         else if (ls_done)
            ls_wait <= 1'b0;
         if (ex_jmp) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= nxt(wr_ptr);
            if (issue)
               rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(issue);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         illegal_instr <= 1'b0;
         ex_pc         <= '0;
         op_lui        <= 1'b0;
         op_auipc      <= 1'b0;
         op_jal        <= 1'b0;
         op_jalr       <= 1'b0;
         op_branch     <= 1'b0;
         op_load       <= 1'b0;
         op_store      <= 1'b0;
         op_imm        <= 1'b0;
         op_reg        <= 1'b0;
         imm_signed    <= '0;
         imm_unsigned  <= '0;
         src1          <= '0;
         src2          <= '0;
         dest          <= '0;
         funct3        <= '0;
         funct7        <= '0;
      end else begin
         ex_valid      <= issue;
         illegal_instr <= issue & ~known;
         if (issue) begin
            ex_pc        <= pc_q[rd_ptr];
            op_lui       <= d_lui;
            op_auipc     <= d_auipc;
            op_jal       <= d_jal;
            op_jalr      <= d_jalr;
            op_branch    <= d_branch;
            op_load      <= d_load;
            op_store     <= d_store;
            op_imm       <= d_imm;
            op_reg       <= d_reg;
            imm_signed   <= imm_sel;
            imm_unsigned <= imm_i;
            src1 <= (d_lui | d_auipc | d_jal) ? 5'd0 : instr[19:15];
            src2 <= instr[24:20];
            dest <= (d_branch | d_store | ~known) ? 5'd0 : instr[11:7];
            funct3       <= instr[14:12];
            funct7       <= instr[31:25];
         end
      end
   end
endmodule

// File: tb/tb_xrv_id.sv
// Randomized bench for xrv_id: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_xrv_id;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] if_pc = '0;
   logic [31:0] if_instr = '0;
   logic        if_ready;
   logic        ex_jmp = 1'b0;
   logic        ncycle_alu_wait = 1'b0;
   logic        ls_done = 1'b0;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        op_lui, op_auipc, op_jal, op_jalr, op_branch;
   logic        op_load, op_store, op_imm, op_reg, op_is_compressed;
   logic [31:0] imm_signed, imm_unsigned;
   logic [4:0]  src1, src2, dest;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        illegal_instr;

   int n_cmp = 0;
   int n_bad = 0;

   xrv_id #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .if_ready(if_ready), .ex_jmp(ex_jmp),
      .ncycle_alu_wait(ncycle_alu_wait), .ls_done(ls_done),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .op_lui(op_lui), .op_auipc(op_auipc), .op_jal(op_jal),
      .op_jalr(op_jalr), .op_branch(op_branch), .op_load(op_load),
      .op_store(op_store), .op_imm(op_imm), .op_reg(op_reg),
      .op_is_compressed(op_is_compressed),
      .imm_signed(imm_signed), .imm_unsigned(imm_unsigned),
      .src1(src1), .src2(src2), .dest(dest),
      .funct3(funct3), .funct7(funct7),
      .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [8:0]  ops;  // lui,auipc,jal,jalr,branch,load,store,imm,reg
      logic        ill;
      logic [31:0] is;
      logic [31:0] iu;
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic [4:0]  d;
      logic [2:0]  f3;
      logic [6:0]  f7;
   } dec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decode straight from the ISA field layouts.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t r;
      logic signed [11:0] i12;
      logic signed [11:0] s12;
      logic signed [12:0] b13;
      logic signed [20:0] j21;
      r = '0;
      i12 = w[31:20];
      s12 = {w[31:25], w[11:7]};
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      r.iu = int'(i12);
      r.s1 = w[19:15];
      r.s2 = w[24:20];
      r.d  = w[11:7];
      r.f3 = w[14:12];
      r.f7 = w[31:25];
      case (w[6:0])
         7'h37: begin r.ops = 9'b100000000; r.is = w & 32'hFFFFF000; r.s1 = 0; end
         7'h17: begin r.ops = 9'b010000000; r.is = w & 32'hFFFFF000; r.s1 = 0; end
         7'h6F: begin r.ops = 9'b001000000; r.is = int'(j21); r.s1 = 0; end
         7'h67: begin r.ops = 9'b000100000; r.is = int'(i12); end
         7'h63: begin r.ops = 9'b000010000; r.is = int'(b13); r.d = 0; end
         7'h03: begin r.ops = 9'b000001000; r.is = int'(i12); end
         7'h23: begin r.ops = 9'b000000100; r.is = int'(s12); r.d = 0; end
         7'h13: begin r.ops = 9'b000000010; r.is = int'(i12); end
         7'h33: r.ops = 9'b000000001;
         7'h0F, 7'h73: ;
         default: begin r.ill = 1'b1; r.d = 0; end
      endcase
      return r;
   endfunction

   logic [63:0] q[$];
   logic        m_lsw = 1'b0;
   logic        m_hold = 1'b0;
   dec_t        e = '0;
   logic [31:0] e_pc = '0;
   logic        e_valid = 1'b0;
   logic        e_ill = 1'b0;
   logic        m_rdy, m_iss;
   logic [63:0] m_w;
   dec_t        m_d;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_lsw = 1'b0; m_hold = 1'b0;
         e = '0; e_pc = '0; e_valid = 1'b0; e_ill = 1'b0;
      end else begin
         m_rdy = q.size() < DEPTH;
         m_iss = q.size() != 0 && !m_lsw && !m_hold && !ex_jmp;
         if (ls_done) m_lsw = 1'b0;
         e_valid = m_iss;
         e_ill = 1'b0;
         if (m_iss) begin
            m_w = q.pop_front();
            m_d = decode(m_w[31:0]);
            e = m_d;
            e_pc = m_w[63:32];
            e_ill = m_d.ill;
            if (m_d.ops[3] || m_d.ops[2]) m_lsw = 1'b1;
         end
         m_hold = ncycle_alu_wait;
         if (ex_jmp) q.delete();
         else if (if_valid && m_rdy) q.push_back({if_pc, if_instr});
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("if_ready", 32'(if_ready), 32'(q.size() < DEPTH));
         chk("ex_valid", 32'(ex_valid), 32'(e_valid));
         chk("illegal", 32'(illegal_instr), 32'(e_ill));
         chk("ops", 32'({op_lui, op_auipc, op_jal, op_jalr, op_branch,
                         op_load, op_store, op_imm, op_reg}), 32'(e.ops));
         chk("compressed", 32'(op_is_compressed), 32'd0);
         chk("ex_pc", ex_pc, e_pc);
         chk("imm_signed", imm_signed, e.is);
         chk("imm_unsigned", imm_unsigned, e.iu);
         chk("src1", 32'(src1), 32'(e.s1));
         chk("src2", 32'(src2), 32'(e.s2));
         chk("dest", 32'(dest), 32'(e.d));
         chk("funct3", 32'(funct3), 32'(e.f3));
         chk("funct7", 32'(funct7), 32'(e.f7));
      end
   end

   task automatic cyc(input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic j,
                      input logic n, input logic l);
      #1;
      if_valid = v; if_pc = pc; if_instr = ins;
      ex_jmp = j; ncycle_alu_wait = n; ls_done = l;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      logic [6:0]  opc [11];
      int k;
      opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
      r = $urandom();
      k = $urandom_range(0, 12);
      if (k < 11) r[6:0] = opc[k];
      return r;
   endfunction

   initial begin
      logic [8:0] ops_now;
      repeat (2) @(negedge clk);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      #1 rst = 1'b0;
      #1 chk("post_rst_ready", 32'(if_ready), 32'd1);

      // stream: ADDI, LUI, BEQ back to back
      cyc(1, 32'h08, 32'h00500093, 0, 0, 0);
      chk("s0_valid", 32'(ex_valid), 32'd0);
      cyc(1, 32'h0C, 32'h12345137, 0, 0, 0);
      chk("addi_valid", 32'(ex_valid), 32'd1);
      chk("addi_op_imm", 32'(op_imm), 32'd1);
      chk("addi_imm", imm_signed, 32'd5);
      chk("addi_dest", 32'(dest), 32'd1);
      cyc(1, 32'h10, 32'h00208463, 0, 0, 0);
      chk("lui_valid", 32'(ex_valid), 32'd1);
      chk("lui_imm", imm_signed, 32'h12345000);
      idle();
      chk("beq_valid", 32'(ex_valid), 32'd1);
      chk("beq_imm", imm_signed, 32'd8);
      chk("beq_dest", 32'(dest), 32'd0);
      chk("beq_pc", ex_pc, 32'h10);
      idle();
      chk("s_end_valid", 32'(ex_valid), 32'd0);

      // load stall
      cyc(1, 32'h20, 32'hFFC0A183, 0, 0, 0);
      cyc(1, 32'h24, 32'h00208233, 0, 0, 0);
      chk("lw_valid", 32'(ex_valid), 32'd1);
      chk("lw_imm", imm_signed, 32'hFFFFFFFC);
      chk("lw_op", 32'(op_load), 32'd1);
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("lw_wait_valid", 32'(ex_valid), 32'd0);
         chk("lw_wait_f3", 32'(funct3), 32'd2);
         chk("lw_wait_dest", 32'(dest), 32'd3);
      end
      cyc(0, 0, 0, 0, 0, 1);
      chk("lsdone_valid", 32'(ex_valid), 32'd0);
      idle();
      chk("add_valid", 32'(ex_valid), 32'd1);
      chk("add_dest", 32'(dest), 32'd4);
      chk("add_op", 32'(op_reg), 32'd1);

      // ALU hold
      cyc(1, 32'h30, 32'h4032D293, 0, 0, 0);
      cyc(1, 32'h34, 32'h00100313, 0, 1, 0);
      chk("srai_valid", 32'(ex_valid), 32'd1);
      chk("srai_f7", 32'(funct7), 32'h20);
      idle();
      chk("hold_valid", 32'(ex_valid), 32'd0);
      idle();
      chk("after_hold_valid", 32'(ex_valid), 32'd1);
      chk("after_hold_dest", 32'(dest), 32'd6);

      // flush with FIFO full
      cyc(1, 32'h40, 32'h00700393, 0, 1, 0);
      cyc(1, 32'h44, 32'h00800413, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("full_ready", 32'(if_ready), 32'd0);
      cyc(1, 32'h48, 32'h00900493, 1, 0, 0);
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_ready", 32'(if_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("flush_drop", 32'(ex_valid), 32'd0);
      end

      // illegal then FENCE
      cyc(1, 32'h50, 32'h00000000, 0, 0, 0);
      cyc(1, 32'h54, 32'h0000000F, 0, 0, 0);
      ops_now = {op_lui, op_auipc, op_jal, op_jalr, op_branch,
                 op_load, op_store, op_imm, op_reg};
      chk("ill_valid", 32'(ex_valid), 32'd1);
      chk("ill_flag", 32'(illegal_instr), 32'd1);
      chk("ill_ops", 32'(ops_now), 32'd0);
      chk("ill_dest", 32'(dest), 32'd0);
      idle();
      ops_now = {op_lui, op_auipc, op_jal, op_jalr, op_branch,
                 op_load, op_store, op_imm, op_reg};
      chk("fence_valid", 32'(ex_valid), 32'd1);
      chk("fence_ill", 32'(illegal_instr), 32'd0);
      chk("fence_ops", 32'(ops_now), 32'd0);

      // reset during load wait with two queued entries
      cyc(1, 32'h60, 32'h0040A283, 0, 0, 0);
      cyc(1, 32'h64, 32'h00100513, 0, 0, 0);
      cyc(1, 32'h68, 32'h00200593, 0, 0, 0);
      chk("rw_full", 32'(if_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("rw_valid", 32'(ex_valid), 32'd0);
      chk("rw_dest", 32'(dest), 32'd0);
      chk("rw_imm", imm_signed, 32'd0);
      chk("rw_ready", 32'(if_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 chk("rw_ready_rel", 32'(if_ready), 32'd1);
      cyc(1, 32'h70, 32'h00300613, 0, 0, 0);
      idle();
      chk("rw_issue", 32'(ex_valid), 32'd1);
      chk("rw_issue_dest", 32'(dest), 32'd12);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom() & 32'hFFFFFFFC,
             rnd_instr(), $urandom_range(0, 19) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
